// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: command, operand, mac-side and result channels of the MAC sequencer.
interface mac_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 64
);
    localparam int LEN_WIDTH = $clog2(MAX_LEN + 1);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] cmd_bias;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  mac_in_valid;
    logic                  mac_in_ready;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic                  mac_overwrite;
    logic [DATA_WIDTH-1:0] mac_overwrite_data;
    logic [DATA_WIDTH-1:0] mac_accumulator;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    modport slave (
        input  cmd_valid, cmd_len, cmd_bias, in_valid, in_a, in_b,
               mac_in_ready, mac_accumulator, out_ready,
        output cmd_ready, in_ready, mac_in_valid, mac_a, mac_b,
               mac_overwrite, mac_overwrite_data, out_valid, out_data
    );
    modport master (
        output cmd_valid, cmd_len, cmd_bias, in_valid, in_a, in_b,
               mac_in_ready, mac_accumulator, out_ready,
        input  cmd_ready, in_ready, mac_in_valid, mac_a, mac_b,
               mac_overwrite, mac_overwrite_data, out_valid, out_data
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one dot-product command through an attached mac and returns one result.
module mac_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_LEN     = 64,
    parameter int MAC_LATENCY = 1
) (
    input  logic            core_clk,
    input  logic            resetn,
    mac_sequencer_if.slave  bus
);
    localparam int LEN_WIDTH = $clog2(MAX_LEN + 1);
    localparam int CW = MAC_LATENCY > 1 ? $clog2(MAC_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, OUTPUT} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d, len_clamped;
    logic [DATA_WIDTH-1:0] bias_q, bias_d, out_data_q, out_data_d;
    logic [CW-1:0]         drain_q, drain_d;
    logic                  out_valid_q, cmd_ready_q, overwrite_q;
    logic                  stream, hs;

    assign stream                 = state_q == STREAM;
    assign bus.in_ready           = stream && bus.mac_in_ready;
    assign bus.mac_in_valid       = stream && bus.in_valid;
    assign hs                     = bus.mac_in_valid && bus.mac_in_ready;
    assign bus.mac_a              = stream ? bus.in_a : '0;
    assign bus.mac_b              = stream ? bus.in_b : '0;
    assign bus.mac_overwrite      = overwrite_q;
    assign bus.mac_overwrite_data = overwrite_q ? bias_q : '0;
    assign bus.cmd_ready          = cmd_ready_q;
    assign bus.out_valid          = out_valid_q;
    assign bus.out_data           = out_data_q;
    assign len_clamped = bus.cmd_len > LEN_WIDTH'(MAX_LEN) ? LEN_WIDTH'(MAX_LEN) : bus.cmd_len;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bias_d      = bias_q;
        drain_d     = drain_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                remaining_d = len_clamped;
                bias_d      = bus.cmd_bias;
                state_d     = CLEAR;
            end
            CLEAR: begin
                drain_d = '0;
                state_d = remaining_q == '0 ? DRAIN : STREAM;
            end
            STREAM: if (hs) begin
                remaining_d = remaining_q - 1'b1;
                state_d     = remaining_q == LEN_WIDTH'(1) ? DRAIN : STREAM;
            end
            // accumulator is only valid once the last update has propagated through the mac
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == CW'(MAC_LATENCY - 1)) begin
                    out_data_d = bus.mac_accumulator;
                    state_d    = OUTPUT;
                end
            end
            OUTPUT: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            bias_q      <= '0;
            drain_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            overwrite_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bias_q      <= bias_d;
            drain_q     <= drain_d;
            out_data_q  <= out_data_d;
            out_valid_q <= state_d == OUTPUT;
            cmd_ready_q <= state_d == IDLE;
            overwrite_q <= state_d == CLEAR;
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives commands and operand streams into mac_sequencer attached to a behavioural mac,
// and compares results and timing against dot products computed directly from the operand arrays.
module tb_mac_sequencer;
    localparam int DW  = 32;
    localparam int ML  = 64;
    localparam int LAT = 1;
    localparam int LW  = $clog2(ML + 1);

    logic core_clk = 1'b0;
    logic resetn   = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0, hs_cnt = 0, mv_cnt = 0, ov_cnt = 0, c0 = 0;
    logic [DW-1:0] ov_data = '0;
    logic [DW-1:0] acc = '0;
    logic [DW-1:0] a_arr[ML];
    logic [DW-1:0] b_arr[ML];
    bit rdy_rand = 1'b0;

    mac_sequencer_if #(.DATA_WIDTH(DW), .MAX_LEN(ML)) bus();

    mac_sequencer #(.DATA_WIDTH(DW), .MAX_LEN(ML), .MAC_LATENCY(LAT)) dut (
        .core_clk(core_clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 core_clk = ~core_clk;

    // behavioural mac with one cycle of latency; overwrite wins over accumulate
    always @(posedge core_clk) begin
        if (bus.mac_overwrite) acc <= bus.mac_overwrite_data;
        else if (bus.mac_in_valid && bus.mac_in_ready) acc <= acc + bus.mac_a * bus.mac_b;
    end
    assign bus.mac_accumulator = acc;

    always @(posedge core_clk) begin
        cyc++;
        if (bus.mac_in_valid) mv_cnt++;
        if (bus.mac_in_valid && bus.mac_in_ready) hs_cnt++;
        if (bus.mac_overwrite) begin
            ov_cnt++;
            ov_data = bus.mac_overwrite_data;
        end
    end

    initial begin
        bus.mac_in_ready = 1'b1;
        forever begin
            @(negedge core_clk);
            bus.mac_in_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    function automatic logic [DW-1:0] dot(input int n, input logic [DW-1:0] bias);
        logic [DW-1:0] s;
        s = bias;
        for (int i = 0; i < n; i++) s = s + a_arr[i] * b_arr[i];
        return s;
    endfunction

    task automatic send_cmd(input int len, input logic [DW-1:0] bias);
        int n;
        n = 0;
        @(negedge core_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        bus.cmd_bias  = bias;
        #1;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge core_clk);
            #1;
            n++;
        end
        checks++;
        if (!bus.cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b expected 1", bus.cmd_ready);
        end
        c0 = cyc;
        @(negedge core_clk);
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = $urandom;
        bus.in_b      = $urandom;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.mac_in_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_gating: in_ready=%b mac_in_valid=%b cmd_ready=%b expected 0 0 0",
                     bus.in_ready, bus.mac_in_valid, bus.cmd_ready);
        end
        checks++;
        if (bus.mac_overwrite !== 1'b1 || bus.mac_overwrite_data !== bias) begin
            errors++;
            $display("FAIL clear_overwrite: ow=%b data=%0d expected 1 %0d",
                     bus.mac_overwrite, bus.mac_overwrite_data, bias);
        end
    endtask

    task automatic feed(input int n, input bit stall);
        int t;
        bit done;
        for (int i = 0; i < n; i++) begin
            t = 0;
            done = 1'b0;
            while (!done && t < 200) begin
                @(negedge core_clk);
                bus.in_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.in_a = a_arr[i];
                bus.in_b = b_arr[i];
                #1;
                if (bus.mac_in_valid) begin
                    checks++;
                    if (bus.mac_a !== a_arr[i] || bus.mac_b !== b_arr[i]) begin
                        errors++;
                        $display("FAIL mac_operands[%0d]: a=%0d b=%0d expected %0d %0d",
                                 i, bus.mac_a, bus.mac_b, a_arr[i], b_arr[i]);
                    end
                end
                done = bus.in_valid && bus.in_ready;
                t++;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL feed_timeout: pair %0d not accepted, in_ready=%b expected 1", i, bus.in_ready);
                return;
            end
        end
    endtask

    task automatic get_result(input logic [DW-1:0] exp, input int exp_lat, input int hold);
        int n;
        logic [DW-1:0] d;
        n = 0;
        do begin
            @(negedge core_clk);
            bus.in_valid = 1'b0;
            #1;
            n++;
        end while (!bus.out_valid && n < 300);
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL result_timeout: out_valid=%b expected 1", bus.out_valid);
            return;
        end
        checks++;
        if (bus.out_data !== exp) begin
            errors++;
            $display("FAIL out_data: got %0d expected %0d", bus.out_data, exp);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (cyc - c0 !== exp_lat) begin
                errors++;
                $display("FAIL out_latency: got cycle %0d expected %0d", cyc - c0, exp_lat);
            end
        end
        d = bus.out_data;
        for (int k = 0; k < hold; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL result_hold[%0d]: valid=%b data=%0d cmd_ready=%b expected 1 %0d 0",
                         k, bus.out_valid, bus.out_data, bus.cmd_ready, d);
            end
            @(negedge core_clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge core_clk);
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: out_valid=%b cmd_ready=%b expected 0 1", bus.out_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.mac_in_valid !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.mac_overwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cmd_ready=%b in_ready=%b miv=%b ov=%b od=%0d ow=%b expected 1 0 0 0 0 0",
                     bus.cmd_ready, bus.in_ready, bus.mac_in_valid, bus.out_valid, bus.out_data, bus.mac_overwrite);
        end
        @(negedge core_clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic;
        int h, o;
        h = hs_cnt;
        o = ov_cnt;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = DW'(i + 1);
            b_arr[i] = DW'(i + 5);
        end
        send_cmd(4, 10);
        feed(4, 1'b0);
        get_result(80, 4 + 2 + LAT, 0);
        checks++;
        if (hs_cnt - h !== 4 || ov_cnt - o !== 1 || ov_data !== 10) begin
            errors++;
            $display("FAIL basic_counts: hs=%0d ow=%0d ow_data=%0d expected 4 1 10", hs_cnt - h, ov_cnt - o, ov_data);
        end
    endtask

    task automatic test_zero_len;
        int m, o;
        m = mv_cnt;
        o = ov_cnt;
        send_cmd(0, 7);
        get_result(7, 2 + LAT, 0);
        checks++;
        if (mv_cnt - m !== 0 || ov_cnt - o !== 1) begin
            errors++;
            $display("FAIL zero_len_counts: mac_in_valid=%0d ow=%0d expected 0 1", mv_cnt - m, ov_cnt - o);
        end
    endtask

    task automatic test_backpressure;
        int h;
        h = hs_cnt;
        for (int i = 0; i < 8; i++) begin
            a_arr[i] = 2;
            b_arr[i] = 2;
        end
        rdy_rand = 1'b1;
        send_cmd(8, 0);
        feed(8, 1'b1);
        rdy_rand = 1'b0;
        get_result(32, -1, 0);
        checks++;
        if (hs_cnt - h !== 8) begin
            errors++;
            $display("FAIL backpressure_hs: got %0d expected 8", hs_cnt - h);
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 2; i++) begin
            a_arr[i] = $urandom;
            b_arr[i] = $urandom;
        end
        send_cmd(2, 3);
        feed(2, 1'b0);
        get_result(dot(2, 3), 2 + 2 + LAT, 5);
    endtask

    task automatic test_clamp;
        int h;
        h = hs_cnt;
        for (int i = 0; i < ML; i++) begin
            a_arr[i] = 1;
            b_arr[i] = 1;
        end
        send_cmd(ML + 5, 0);
        feed(ML, 1'b0);
        get_result(ML, ML + 2 + LAT, 0);
        checks++;
        if (hs_cnt - h !== ML) begin
            errors++;
            $display("FAIL clamp_hs: got %0d expected %0d", hs_cnt - h, ML);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = DW'(i + 9);
            b_arr[i] = DW'(i + 2);
        end
        send_cmd(4, 5);
        feed(2, 1'b0);
        @(negedge core_clk);
        bus.in_valid = 1'b1;
        bus.in_a = a_arr[2];
        bus.in_b = b_arr[2];
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.in_ready !== 1'b0 || bus.mac_in_valid !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.mac_overwrite !== 1'b0 || bus.mac_a !== '0) begin
            errors++;
            $display("FAIL mid_reset: cmd_ready=%b in_ready=%b miv=%b ov=%b od=%0d ow=%b mac_a=%0d expected 1 0 0 0 0 0 0",
                     bus.cmd_ready, bus.in_ready, bus.mac_in_valid, bus.out_valid, bus.out_data,
                     bus.mac_overwrite, bus.mac_a);
        end
        bus.in_valid = 1'b0;
        @(negedge core_clk);
        resetn = 1'b1;
        a_arr[0] = 3;
        b_arr[0] = 3;
        send_cmd(1, 1);
        feed(1, 1'b0);
        get_result(10, 1 + 2 + LAT, 0);
    endtask

    task automatic test_random;
        int n, h;
        logic [DW-1:0] bias;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 12);
            bias = $urandom;
            for (int i = 0; i < n; i++) begin
                a_arr[i] = $urandom;
                b_arr[i] = $urandom;
            end
            h = hs_cnt;
            rdy_rand = 1'b1;
            send_cmd(n, bias);
            feed(n, 1'b1);
            rdy_rand = 1'b0;
            get_result(dot(n, bias), -1, $urandom_range(0, 2));
            checks++;
            if (hs_cnt - h !== n) begin
                errors++;
                $display("FAIL random_hs[%0d]: got %0d expected %0d", r, hs_cnt - h, n);
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_bias  = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge core_clk);
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_hold();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
